// File: rtl/bus_capture_writer.sv
// rtl/bus_capture_writer.sv - Triggered sample capture into the write port of a bus-readable sample RAM
// Optional feature: CAPTURE_DECIMATE_EN adds the DECIM register (0x08) and sample decimation.
module bus_capture_writer #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_Bus_Clk,
    input  logic          i_Bus_Rst,
    input  logic          i_Bus_CS,
    input  logic          i_Bus_Wr_Rd_n,
    input  logic [15:0]   i_Bus_Addr8,
    input  logic [15:0]   i_Bus_Wr_Data,
    output logic [15:0]   o_Bus_Rd_Data,
    output logic          o_Bus_Rd_DV,
    input  logic          i_Trigger,
    input  logic          i_Sample_DV,
    input  logic [15:0]   i_Sample_Data,
    output logic [AW-1:0] o_Wr_Addr,
    output logic          o_Wr_DV,
    output logic [15:0]   o_Wr_Data,
    output logic          o_Irq
);

    localparam int          LW      = AW + 1;
    localparam logic [AW:0] C_DEPTH = LW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [AW:0]   r_length;
    logic          r_cont;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_addr;
    logic          r_wrapped;
    logic          r_triggered;
    logic          r_wr_dv;
    logic [AW-1:0] r_wr_addr;
    logic [15:0]   r_wr_data;
    logic          r_irq;
    logic          r_rd_dv;
    logic [15:0]   r_rd_data;

    logic          w_wr;
    logic          w_rd;
    logic [2:0]    w_reg;
    logic          w_ctrl_wr;
    logic          w_arm;
    logic          w_abort;
    logic          w_busy;
    logic [AW:0]   w_eff_len;
    logic          w_strobe;
    logic          w_accept;
    logic          w_last;
    logic          w_addr_end;
    logic          w_done_hit;
    logic [15:0]   w_rd_mux;
    logic          w_unused;

    assign w_wr      = i_Bus_CS & i_Bus_Wr_Rd_n;
    assign w_rd      = i_Bus_CS & ~i_Bus_Wr_Rd_n;
    assign w_reg     = i_Bus_Addr8[3:1];
    assign w_ctrl_wr = w_wr && (w_reg == 3'd0);
    // ABORT beats ARM when both arrive in one CTRL write
    assign w_abort   = w_ctrl_wr && i_Bus_Wr_Data[1];
    assign w_arm     = w_ctrl_wr && i_Bus_Wr_Data[0] && !i_Bus_Wr_Data[1];
    assign w_busy    = (r_state == S_ARMED) || (r_state == S_CAPTURE);

    assign w_eff_len = ((r_length == '0) || (r_length > C_DEPTH)) ? C_DEPTH : r_length;

    // The trigger cycle itself can already deliver sample index 0
    assign w_strobe  = i_Sample_DV &&
                       ((r_state == S_CAPTURE) || ((r_state == S_ARMED) && i_Trigger));

`ifdef CAPTURE_DECIMATE_EN
    logic [7:0] r_decim;
    logic [7:0] r_dec_cnt;

    assign w_accept = w_strobe && (r_dec_cnt == 8'd0);
    assign w_unused = ^{i_Bus_Addr8[15:4], i_Bus_Addr8[0], i_Bus_Wr_Data[15:AW+1]};

    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            r_decim   <= 8'd0;
            r_dec_cnt <= 8'd0;
        end else begin
            if (w_wr && (w_reg == 3'd4)) begin
                r_decim <= i_Bus_Wr_Data[7:0];
            end
            if (w_arm && !w_busy) begin
                r_dec_cnt <= 8'd0;
            end else if (w_strobe) begin
                r_dec_cnt <= (r_dec_cnt >= r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
            end
        end
    end
`else
    assign w_accept = w_strobe;
    assign w_unused = ^{i_Bus_Addr8[15:4], i_Bus_Addr8[0], i_Bus_Wr_Data[15:AW+1]};
`endif

    assign w_last     = ((r_count + 1'b1) == w_eff_len);
    assign w_addr_end = ({1'b0, r_addr} == (w_eff_len - 1'b1));
    assign w_done_hit = w_accept && w_last && !r_cont;

    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arm) w_next_state = S_ARMED;
            end
            S_ARMED: begin
                if (w_abort)        w_next_state = S_DONE;
                else if (i_Trigger) w_next_state = w_done_hit ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_abort || w_done_hit) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_arm) w_next_state = S_ARMED;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            r_length    <= '0;
            r_cont      <= 1'b0;
            r_count     <= '0;
            r_addr      <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_wr_dv     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr && (w_reg == 3'd1)) begin
                r_length <= i_Bus_Wr_Data[AW:0];
            end
            if (w_ctrl_wr && !w_busy) begin
                r_cont <= i_Bus_Wr_Data[2];
            end

            if (w_arm && !w_busy) begin
                r_count     <= '0;
                r_addr      <= '0;
                r_wrapped   <= 1'b0;
                r_triggered <= 1'b0;
            end else begin
                if ((r_state == S_ARMED) && i_Trigger && !w_abort) begin
                    r_triggered <= 1'b1;
                end
                if (w_accept) begin
                    if (r_cont && w_addr_end) begin
                        r_addr    <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                    // Continuous mode keeps COUNT pinned at the buffer length
                    if (r_count < w_eff_len) begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end

            r_wr_dv <= w_accept;
            if (w_accept) begin
                r_wr_addr <= r_addr;
                r_wr_data <= i_Sample_Data;
            end
            r_irq <= (w_next_state == S_DONE) && (r_state != S_DONE);
        end
    end

    always_comb begin
        w_rd_mux = 16'h0000;
        case (w_reg)
            3'd0:    w_rd_mux[2]   = r_cont;
            3'd1:    w_rd_mux      = 16'(r_length);
            3'd2:    w_rd_mux[3:0] = {r_triggered, r_wrapped, (r_state == S_DONE), w_busy};
            3'd3:    w_rd_mux      = 16'(r_count);
`ifdef CAPTURE_DECIMATE_EN
            3'd4:    w_rd_mux[7:0] = r_decim;
`endif
            default: w_rd_mux      = 16'h0000;
        endcase
    end

    always_ff @(posedge i_Bus_Clk) begin
        if (i_Bus_Rst) begin
            r_rd_dv   <= 1'b0;
            r_rd_data <= 16'h0000;
        end else begin
            r_rd_dv   <= w_rd;
            r_rd_data <= w_rd ? w_rd_mux : 16'h0000;
        end
    end

    assign o_Bus_Rd_Data = r_rd_data;
    assign o_Bus_Rd_DV   = r_rd_dv;
    assign o_Wr_Addr     = r_wr_addr;
    assign o_Wr_DV       = r_wr_dv;
    assign o_Wr_Data     = r_wr_data;
    assign o_Irq         = r_irq;

endmodule

// File: tb/tb_bus_capture_writer.sv
// tb/tb_bus_capture_writer.sv - Randomized self-checking bench for bus_capture_writer
module tb_bus_capture_writer;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          wr_rd_n = 1'b0;
    logic [15:0]   addr = '0;
    logic [15:0]   wdata = '0;
    logic [15:0]   rd_data;
    logic          rd_dv;
    logic          trig = 1'b0;
    logic          sdv = 1'b0;
    logic [15:0]   sdata = '0;
    logic [AW-1:0] wr_addr;
    logic          wr_dv;
    logic [15:0]   wr_data;
    logic          irq;

    bus_capture_writer #(.DEPTH(DEPTH)) dut (
        .i_Bus_Clk    (clk),
        .i_Bus_Rst    (rst),
        .i_Bus_CS     (cs),
        .i_Bus_Wr_Rd_n(wr_rd_n),
        .i_Bus_Addr8  (addr),
        .i_Bus_Wr_Data(wdata),
        .o_Bus_Rd_Data(rd_data),
        .o_Bus_Rd_DV  (rd_dv),
        .i_Trigger    (trig),
        .i_Sample_DV  (sdv),
        .i_Sample_Data(sdata),
        .o_Wr_Addr    (wr_addr),
        .o_Wr_DV      (wr_dv),
        .o_Wr_Data    (wr_data),
        .o_Irq        (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [31:0] wr_log[$];
    int          irq_cnt = 0;
    logic        irq_wr = 1'b0;

    always @(negedge clk) begin
        if (wr_dv) wr_log.push_back({8'h00, wr_addr, wr_data});
        if (irq) begin
            irq_cnt++;
            irq_wr = wr_dv;
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr_rd_n = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr_rd_n = 1'b0;
    endtask

    task automatic reg_check(input logic [15:0] a, input logic [15:0] exp, input string tag);
        @(posedge clk); #1;
        cs = 1'b1; wr_rd_n = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
        @(negedge clk);
        check({tag, "_dv"}, {31'd0, rd_dv}, 32'd1);
        check(tag, {16'd0, rd_data}, {16'd0, exp});
    endtask

    task automatic drive(input logic t, input logic v, input logic [15:0] d);
        @(posedge clk); #1;
        trig = t; sdv = v; sdata = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0000);
    endtask

    // Reference model state for one capture run
    logic [31:0] exp_q[$];
    int          m_k, m_a, m_eff, m_decim;
    bit          m_cont, m_prev_acc;

    // One cycle of stimulus: the model decides from the capture rules alone
    // whether this sample lands in RAM, and where.
    task automatic cap_cycle(input logic t, input logic v, input logic [15:0] d, input bit in_cap,
                             input string tag);
        bit acc;
        drive(t, v, d);
        acc = 1'b0;
        if (in_cap && v) begin
            if ((m_k % (m_decim + 1)) == 0) begin
                if (m_cont || m_a < m_eff) begin
                    acc = 1'b1;
                    exp_q.push_back({8'h00, 8'(m_a % m_eff), d});
                end
                m_a++;
            end
            m_k++;
        end
        @(negedge clk);
        check({tag, "_wrdv"}, {31'd0, wr_dv}, {31'd0, m_prev_acc});
        m_prev_acc = acc;
    endtask

    task automatic run_capture(input string tag, input int len, input bit cont, input int nsamp,
                               input int dens, input int pre, input logic [15:0] base,
                               input bit use_base, input int decim);
        bit          first;
        bit          need_abort;
        int          nexp;
        logic [15:0] d;
        m_eff    = (len == 0 || len > DEPTH) ? DEPTH : len;
        m_cont   = cont;
        m_k      = 0;
        m_a      = 0;
        m_prev_acc = 1'b0;
`ifdef CAPTURE_DECIMATE_EN
        m_decim  = decim;
        bus_write(16'h0008, 16'(decim));
`else
        m_decim  = 0;
`endif
        exp_q.delete();
        bus_write(16'h0002, 16'(len));
        wr_log.delete();
        irq_cnt = 0;
        irq_wr  = 1'b0;
        bus_write(16'h0000, {13'd0, cont, 2'b01});
        for (int i = 0; i < pre; i++)
            cap_cycle(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, tag);
        first = 1'b1;
        while (first || m_k < nsamp) begin
            d = use_base ? base + 16'(m_k) : 16'($urandom);
            cap_cycle(first ? 1'b1 : 1'($urandom_range(0, 1)),
                      (m_k < nsamp) && ($urandom_range(0, 99) < dens), d, 1'b1, tag);
            first = 1'b0;
        end
        cap_cycle(1'b0, 1'b0, 16'h0000, 1'b0, tag);
        need_abort = cont || (m_a < m_eff);
        if (need_abort) bus_write(16'h0000, 16'h0002);
        idle(3);
        nexp = exp_q.size();
        check({tag, "_nwr"}, wr_log.size(), nexp);
        for (int i = 0; i < nexp && i < wr_log.size(); i++)
            check({tag, "_wr"}, wr_log[i], exp_q[i]);
        check({tag, "_irq"}, irq_cnt, 1);
        if (!need_abort) check({tag, "_irq_last"}, {31'd0, irq_wr}, 32'd1);
        reg_check(16'h0004, {12'd0, 1'b1, (cont && m_a >= m_eff), 1'b1, 1'b0}, {tag, "_status"});
        reg_check(16'h0006, 16'((m_a < m_eff) ? m_a : m_eff), {tag, "_count"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int len, dens, nsamp;
        bit cont;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_outs", {wr_dv, irq, rd_dv, wr_addr, wr_data, rd_data}, 32'd0);
        reg_check(16'h0004, 16'h0000, "rst_status");
        @(negedge clk);
        check("rd_dv_single", {31'd0, rd_dv}, 32'd0);
        reg_check(16'h0006, 16'h0000, "rst_count");
        reg_check(16'h0002, 16'h0000, "rst_length");
        reg_check(16'h0000, 16'h0000, "rst_ctrl");

        bus_write(16'h0000, 16'h0002);
        reg_check(16'h0004, 16'h0000, "abort_idle");
        bus_write(16'h000C, 16'hFFFF);
        reg_check(16'h000C, 16'h0000, "unmapped_c");
        reg_check(16'h000A, 16'h0000, "unmapped_a");
        bus_write(16'h0008, 16'h0105);
`ifdef CAPTURE_DECIMATE_EN
        reg_check(16'h0008, 16'h0005, "decim_rb");
        bus_write(16'h0008, 16'h0000);
`else
        reg_check(16'h0008, 16'h0000, "decim_unmapped");
`endif

        run_capture("oneshot4", 4, 1'b0, 6, 100, 0, 16'hA000, 1'b1, 0);
        run_capture("cont3", 3, 1'b1, 5, 100, 0, 16'hC000, 1'b1, 0);
        run_capture("full_depth", 0, 1'b0, 258, 100, 2, 16'h0000, 1'b0, 0);
        run_capture("over_depth", 300, 1'b1, 260, 90, 1, 16'h0000, 1'b0, 0);
`ifdef CAPTURE_DECIMATE_EN
        run_capture("decim2", 2, 1'b0, 6, 100, 0, 16'hD000, 1'b1, 2);
`endif

        // ARM together with ABORT while armed
        bus_write(16'h0002, 16'h0004);
        bus_write(16'h0000, 16'h0001);
        reg_check(16'h0004, 16'h0001, "armed_status");
        wr_log.delete();
        irq_cnt = 0;
        drive(1'b0, 1'b1, 16'h1234);
        drive(1'b0, 1'b0, 16'h0000);
        bus_write(16'h0000, 16'h0003);
        idle(3);
        reg_check(16'h0004, 16'h0002, "armabort_status");
        check("armabort_nwr", wr_log.size(), 0);
        check("armabort_irq", irq_cnt, 1);

        // ARM and CONT change during capture are both ignored
        bus_write(16'h0000, 16'h0001);
        wr_log.delete();
        irq_cnt = 0;
        drive(1'b1, 1'b1, 16'hB000);
        drive(1'b0, 1'b1, 16'hB001);
        drive(1'b0, 1'b0, 16'h0000);
        bus_write(16'h0000, 16'h0005);
        reg_check(16'h0000, 16'h0000, "busy_ctrl");
        reg_check(16'h0004, 16'h0009, "busy_status");
        reg_check(16'h0006, 16'h0002, "busy_count");
        drive(1'b0, 1'b1, 16'hB002);
        drive(1'b0, 1'b1, 16'hB003);
        idle(3);
        reg_check(16'h0004, 16'h000A, "rearm_status");
        reg_check(16'h0006, 16'h0004, "rearm_count");
        check("rearm_nwr", wr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_log.size(); i++)
            check("rearm_wr", wr_log[i], {8'h00, 8'(i), 16'hB000 + 16'(i)});

        for (int r = 0; r < 12; r++) begin
            len   = ($urandom_range(0, 9) == 0) ? 300 : $urandom_range(0, 10);
            cont  = 1'($urandom_range(0, 1));
            dens  = $urandom_range(30, 100);
            nsamp = (len == 0 || len > DEPTH) ? $urandom_range(0, 20) : $urandom_range(0, 2 * len + 3);
            run_capture($sformatf("rand%0d", r), len, cont, nsamp, dens, $urandom_range(0, 3),
                        16'h0000, 1'b0, $urandom_range(0, 3));
        end

        // Reset in the middle of a capture
        bus_write(16'h0002, 16'h0000);
        bus_write(16'h0000, 16'h0001);
        drive(1'b1, 1'b1, 16'hE000);
        drive(1'b0, 1'b1, 16'hE001);
        drive(1'b0, 1'b1, 16'hE002);
        @(posedge clk); #1;
        rst = 1'b1; sdv = 1'b1; sdata = 16'hE003;
        @(posedge clk); #1;
        rst = 1'b0; sdv = 1'b0; trig = 1'b0;
        @(negedge clk);
        check("rst_mid_wrdv", {31'd0, wr_dv}, 32'd0);
        reg_check(16'h0000, 16'h0000, "rst_mid_ctrl");
        reg_check(16'h0002, 16'h0000, "rst_mid_length");
        reg_check(16'h0004, 16'h0000, "rst_mid_status");
        reg_check(16'h0006, 16'h0000, "rst_mid_count");
`ifdef CAPTURE_DECIMATE_EN
        reg_check(16'h0008, 16'h0000, "rst_mid_decim");
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
